// File: rtl/vx_wb_pkg.sv
// Shared writeback types and constants: source indices, commit beat layout, thread popcount.
// Imported by the arbiter, its handshake interface and the bench.
package vx_wb_pkg;
   localparam int NUM_REQS    = 5;
   localparam int NUM_THREADS = 4;
   localparam int NW_BITS     = 2;
   localparam int XLEN        = 32;
   localparam int RD_BITS     = 5;
   localparam int PERF_W      = 44;
   localparam int REQ_IDX_W   = $clog2(NUM_REQS);

   localparam logic [REQ_IDX_W-1:0] WB_ALU = REQ_IDX_W'(0);
   localparam logic [REQ_IDX_W-1:0] WB_LSU = REQ_IDX_W'(1);
   localparam logic [REQ_IDX_W-1:0] WB_CSR = REQ_IDX_W'(2);
   localparam logic [REQ_IDX_W-1:0] WB_FPU = REQ_IDX_W'(3);
   localparam logic [REQ_IDX_W-1:0] WB_GPU = REQ_IDX_W'(4);

   typedef struct packed {
      logic [NW_BITS-1:0]          wid;
      logic [XLEN-1:0]             pc;
      logic [NUM_THREADS-1:0]      tmask;
      logic [RD_BITS-1:0]          rd;
      logic [NUM_THREADS*XLEN-1:0] data;
      logic                        eop;
   } wb_beat_t;

   function automatic logic [PERF_W-1:0] popcount_tmask(input logic [NUM_THREADS-1:0] m);
      logic [PERF_W-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         c = c + PERF_W'(m[i]);
      end
      return c;
   endfunction
endpackage

// File: rtl/vx_writeback_arbiter_if.sv
// Commit-side handshake and writeback-side bus of the writeback arbiter.
// master = execute units / consumer view, slave = arbiter view.
interface vx_writeback_arbiter_if;
   import vx_wb_pkg::*;

   logic [NUM_REQS-1:0]                  cmt_valid;
   logic [NUM_REQS-1:0]                  cmt_ready;
   logic [NUM_REQS*NW_BITS-1:0]          cmt_wid;
   logic [NUM_REQS*XLEN-1:0]             cmt_pc;
   logic [NUM_REQS*NUM_THREADS-1:0]      cmt_tmask;
   logic [NUM_REQS-1:0]                  cmt_wb;
   logic [NUM_REQS*RD_BITS-1:0]          cmt_rd;
   logic [NUM_REQS*NUM_THREADS*XLEN-1:0] cmt_data;
   logic [NUM_REQS-1:0]                  cmt_eop;

   logic                                 wb_valid;
   logic [NW_BITS-1:0]                   wb_wid;
   logic [XLEN-1:0]                      wb_pc;
   logic [NUM_THREADS-1:0]               wb_tmask;
   logic [RD_BITS-1:0]                   wb_rd;
   logic [NUM_THREADS*XLEN-1:0]          wb_data;
   logic                                 wb_eop;
   logic [PERF_W-1:0]                    perf_wb_beats;
   logic [PERF_W-1:0]                    perf_wb_threads;

   modport master (
      output cmt_valid, cmt_wid, cmt_pc, cmt_tmask, cmt_wb, cmt_rd, cmt_data, cmt_eop,
      input  cmt_ready,
      input  wb_valid, wb_wid, wb_pc, wb_tmask, wb_rd, wb_data, wb_eop,
      input  perf_wb_beats, perf_wb_threads
   );

   modport slave (
      input  cmt_valid, cmt_wid, cmt_pc, cmt_tmask, cmt_wb, cmt_rd, cmt_data, cmt_eop,
      output cmt_ready,
      output wb_valid, wb_wid, wb_pc, wb_tmask, wb_rd, wb_data, wb_eop,
      output perf_wb_beats, perf_wb_threads
   );
endinterface

// File: rtl/vx_rr_lock_arbiter.sv
// Combinational round-robin arbiter with packet lock: one-hot grant from req, lock state and rr pointer.
// Zero latency; while locked only lock_idx can win, so an idle lock owner yields no grant.
module vx_rr_lock_arbiter #(
   parameter int N     = 5,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic             lock,
   input  logic [IDX_W-1:0] lock_idx,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_vld
);
   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      if (lock) begin
         if (req[lock_idx]) begin
            grant[lock_idx] = 1'b1;
            grant_idx       = lock_idx;
            grant_vld       = 1'b1;
         end
      end else begin
         // Scan in wrap order starting at the pointer; first requester wins.
         for (int i = 0; i < N; i++) begin
            idx = (int'(rr_ptr) + i) % N;
            if (!grant_vld && req[idx]) begin
               grant[idx] = 1'b1;
               grant_idx  = IDX_W'(idx);
               grant_vld  = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/vx_writeback_arbiter.sv
// Merges commit beats from ALU/LSU/CSR/FPU/GPU onto one registered GPR writeback port, 1 beat/cycle.
// Latency 1 cycle; commit sources are backpressured via combinational cmt_ready, writeback has none.
module vx_writeback_arbiter
   import vx_wb_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   vx_writeback_arbiter_if.slave bus
);
   logic [NUM_REQS-1:0]  req;
   logic [NUM_REQS-1:0]  grant;
   logic [REQ_IDX_W-1:0] grant_idx;
   logic                 grant_vld;
   logic [REQ_IDX_W-1:0] rr_ptr;
   logic                 lock;
   logic [REQ_IDX_W-1:0] lock_idx;
   wb_beat_t             beat;
   wb_beat_t             wb_q;
   logic                 wb_vld_q;
   logic [PERF_W-1:0]    perf_beats_q;
   logic [PERF_W-1:0]    perf_threads_q;

   assign req = reset ? '0 : (bus.cmt_valid & bus.cmt_wb);

   // Commits without a writeback are acknowledged directly, outside arbitration.
   assign bus.cmt_ready = reset ? '0 : ((bus.cmt_valid & ~bus.cmt_wb) | grant);

   vx_rr_lock_arbiter #(
      .N     (NUM_REQS),
      .IDX_W (REQ_IDX_W)
   ) u_arb (
      .req       (req),
      .lock      (lock),
      .lock_idx  (lock_idx),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   always_comb begin
      beat.wid   = bus.cmt_wid[grant_idx*NW_BITS +: NW_BITS];
      beat.pc    = bus.cmt_pc[grant_idx*XLEN +: XLEN];
      beat.tmask = bus.cmt_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
      beat.rd    = bus.cmt_rd[grant_idx*RD_BITS +: RD_BITS];
      beat.data  = bus.cmt_data[grant_idx*NUM_THREADS*XLEN +: NUM_THREADS*XLEN];
      beat.eop   = bus.cmt_eop[grant_idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_vld_q       <= 1'b0;
         wb_q           <= '0;
         rr_ptr         <= WB_ALU;
         lock           <= 1'b0;
         lock_idx       <= '0;
         perf_beats_q   <= '0;
         perf_threads_q <= '0;
      end else begin
         wb_vld_q <= grant_vld;
         if (grant_vld) begin
            wb_q <= beat;
            // The pointer only moves once a whole packet has gone through.
            if (beat.eop) begin
               lock   <= 1'b0;
               rr_ptr <= (grant_idx == WB_GPU) ? WB_ALU : grant_idx + REQ_IDX_W'(1);
            end else begin
               lock     <= 1'b1;
               lock_idx <= grant_idx;
            end
         end
         if (wb_vld_q) begin
            perf_beats_q   <= perf_beats_q + PERF_W'(1);
            perf_threads_q <= perf_threads_q + popcount_tmask(wb_q.tmask);
         end
      end
   end

   assign bus.wb_valid        = wb_vld_q;
   assign bus.wb_wid          = wb_q.wid;
   assign bus.wb_pc           = wb_q.pc;
   assign bus.wb_tmask        = wb_q.tmask;
   assign bus.wb_rd           = wb_q.rd;
   assign bus.wb_data         = wb_q.data;
   assign bus.wb_eop          = wb_q.eop;
   assign bus.perf_wb_beats   = perf_beats_q;
   assign bus.perf_wb_threads = perf_threads_q;

   // While locked, the previous beat in wb_q belongs to the same packet.
   a_lock_stable: assert property (@(posedge clk) disable iff (reset)
      (lock && grant_vld) |-> (beat.wid == wb_q.wid && beat.rd == wb_q.rd));
endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Directed bench for vx_writeback_arbiter: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_vx_writeback_arbiter;
   import vx_wb_pkg::*;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   int   k [NUM_REQS];
   int   order [6];
   wb_beat_t expq [$];

   vx_writeback_arbiter_if bus ();

   vx_writeback_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic wb_beat_t mk(input logic [NW_BITS-1:0] wid, input logic [RD_BITS-1:0] rd,
                                   input logic [NUM_THREADS-1:0] tm, input logic [XLEN-1:0] tag,
                                   input logic eop);
      wb_beat_t b;
      b.wid   = wid;
      b.pc    = tag;
      b.tmask = tm;
      b.rd    = rd;
      b.eop   = eop;
      b.data  = '0;
      for (int l = 0; l < NUM_THREADS; l++) begin
         b.data[l*XLEN +: XLEN] = tag + XLEN'(l) * 32'h0001_0001;
      end
      return b;
   endfunction

   task automatic drive(input int s, input logic w, input wb_beat_t b);
      bus.cmt_valid[s] = 1'b1;
      bus.cmt_wb[s]    = w;
      bus.cmt_eop[s]   = b.eop;
      bus.cmt_wid[s*NW_BITS +: NW_BITS]                            = b.wid;
      bus.cmt_pc[s*XLEN +: XLEN]                                   = b.pc;
      bus.cmt_tmask[s*NUM_THREADS +: NUM_THREADS]                  = b.tmask;
      bus.cmt_rd[s*RD_BITS +: RD_BITS]                             = b.rd;
      bus.cmt_data[s*NUM_THREADS*XLEN +: NUM_THREADS*XLEN]         = b.data;
   endtask

   task automatic idle(input int s);
      bus.cmt_valid[s] = 1'b0;
   endtask

   task automatic clear_all();
      bus.cmt_valid = '0;
      bus.cmt_wb    = '0;
      bus.cmt_eop   = '0;
      bus.cmt_wid   = '0;
      bus.cmt_pc    = '0;
      bus.cmt_tmask = '0;
      bus.cmt_rd    = '0;
      bus.cmt_data  = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_all();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      wb_beat_t got;
      wb_beat_t e;
      if (bus.wb_valid === 1'b1) begin
         got.wid   = bus.wb_wid;
         got.pc    = bus.wb_pc;
         got.tmask = bus.wb_tmask;
         got.rd    = bus.wb_rd;
         got.data  = bus.wb_data;
         got.eop   = bus.wb_eop;
         n_vec++;
         if (expq.size() == 0) begin
            n_err++;
            $display("FAIL wb_beat: got unexpected beat pc=%h rd=%0d, expected no beat", got.pc, got.rd);
         end else begin
            e = expq.pop_front();
            if (got !== e) begin
               n_err++;
               $display("FAIL wb_beat: got wid=%0d pc=%h tm=%b rd=%0d eop=%b data=%h, expected wid=%0d pc=%h tm=%b rd=%0d eop=%b data=%h",
                        got.wid, got.pc, got.tmask, got.rd, got.eop, got.data,
                        e.wid, e.pc, e.tmask, e.rd, e.eop, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      wb_beat_t b, a1, c;
      n_vec = 0;
      n_err = 0;
      order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0; order[4] = 1; order[5] = 3;
      reset = 1'b1;
      clear_all();

      // Reset state, with a valid ALU beat that must not be accepted.
      drive(WB_ALU, 1'b1, mk(2'd1, 5'd1, 4'hF, 32'hDEAD_0000, 1'b1));
      step();
      step();
      check("rst_ready", bus.cmt_ready, 0);
      check("rst_wb_valid", bus.wb_valid, 0);
      check("rst_wb_rd", bus.wb_rd, 0);
      check("rst_wb_pc", bus.wb_pc, 0);
      check("rst_beats", bus.perf_wb_beats, 0);
      check("rst_threads", bus.perf_wb_threads, 0);
      clear_all();
      reset = 1'b0;

      // 1: single ALU beat.
      b = mk(2'd1, 5'd7, 4'b1011, 32'h1111_0000, 1'b1);
      drive(WB_ALU, 1'b1, b);
      #1 check("t1_ready", bus.cmt_ready, 5'b00001);
      expq.push_back(b);
      step();
      idle(WB_ALU);
      step();
      step();
      check("t1_beats", bus.perf_wb_beats, 1);
      check("t1_threads", bus.perf_wb_threads, 3);

      // 2: ALU, LSU, FPU contending every cycle.
      do_reset();
      for (int s = 0; s < NUM_REQS; s++) k[s] = 0;
      for (int c = 0; c < 6; c++) begin
         drive(WB_ALU, 1'b1, mk(2'd0, 5'd1, 4'hF, 32'h2000_0000 + k[0], 1'b1));
         drive(WB_LSU, 1'b1, mk(2'd1, 5'd2, 4'hF, 32'h2000_0100 + k[1], 1'b1));
         drive(WB_FPU, 1'b1, mk(2'd3, 5'd4, 4'hF, 32'h2000_0300 + k[3], 1'b1));
         expq.push_back(mk(2'(order[c]), 5'(order[c] + 1), 4'hF,
                           32'h2000_0000 + 32'(order[c] * 256) + k[order[c]], 1'b1));
         #1 check("t2_ready", bus.cmt_ready, 64'(NUM_REQS'(1) << order[c]));
         k[order[c]]++;
         step();
      end
      clear_all();
      step();
      step();
      check("t2_beats", bus.perf_wb_beats, 6);
      check("t2_threads", bus.perf_wb_threads, 24);

      // 3: LSU 3-beat packet with a valid gap, ALU waiting throughout.
      do_reset();
      b = mk(2'd0, 5'd3, 4'b0001, 32'h3000_0000, 1'b1);
      drive(WB_ALU, 1'b1, b);
      expq.push_back(b);
      #1 check("t3_alu_first", bus.cmt_ready, 5'b00001);
      step();
      a1 = mk(2'd0, 5'd4, 4'b0011, 32'h3000_0001, 1'b1);
      drive(WB_ALU, 1'b1, a1);
      b = mk(2'd1, 5'd10, 4'hF, 32'h3100_0000, 1'b0);
      drive(WB_LSU, 1'b1, b);
      expq.push_back(b);
      #1 check("t3_lsu_b0", bus.cmt_ready, 5'b00010);
      step();
      idle(WB_LSU);
      #1 check("t3_gap_stall", bus.cmt_ready, 5'b00000);
      step();
      b = mk(2'd1, 5'd10, 4'hF, 32'h3100_0001, 1'b0);
      drive(WB_LSU, 1'b1, b);
      expq.push_back(b);
      #1 check("t3_lsu_b1", bus.cmt_ready, 5'b00010);
      step();
      b = mk(2'd1, 5'd10, 4'hF, 32'h3100_0002, 1'b1);
      drive(WB_LSU, 1'b1, b);
      expq.push_back(b);
      #1 check("t3_lsu_b2", bus.cmt_ready, 5'b00010);
      step();
      idle(WB_LSU);
      expq.push_back(a1);
      #1 check("t3_alu_after", bus.cmt_ready, 5'b00001);
      step();
      clear_all();
      step();
      step();
      check("t3_beats", bus.perf_wb_beats, 5);

      // 4: CSR sink path alongside an ALU writeback.
      do_reset();
      c = mk(2'd2, 5'd3, 4'hF, 32'hC5C5_0000, 1'b1);
      drive(WB_CSR, 1'b0, c);
      b = mk(2'd3, 5'd9, 4'b0110, 32'h4444_0000, 1'b1);
      drive(WB_ALU, 1'b1, b);
      expq.push_back(b);
      #1 check("t4_ready", bus.cmt_ready, 5'b00101);
      step();
      clear_all();
      step();
      step();
      check("t4_beats", bus.perf_wb_beats, 1);
      check("t4_threads", bus.perf_wb_threads, 2);

      // 5: reset in the middle of a locked LSU packet.
      do_reset();
      b = mk(2'd2, 5'd12, 4'hF, 32'h5555_0000, 1'b0);
      drive(WB_LSU, 1'b1, b);
      expq.push_back(b);
      step();
      reset = 1'b1;
      drive(WB_LSU, 1'b1, mk(2'd2, 5'd12, 4'hF, 32'h5555_0001, 1'b0));
      #1 check("t5_rst_ready", bus.cmt_ready, 0);
      step();
      check("t5_wb_valid", bus.wb_valid, 0);
      check("t5_beats", bus.perf_wb_beats, 0);
      check("t5_threads", bus.perf_wb_threads, 0);
      reset = 1'b0;
      idle(WB_LSU);
      b = mk(2'd1, 5'd20, 4'b0001, 32'h6666_0000, 1'b1);
      drive(WB_GPU, 1'b1, b);
      expq.push_back(b);
      #1 check("t5_gpu_ready", bus.cmt_ready, 5'b10000);
      step();
      clear_all();
      step();
      step();
      check("t5_gpu_threads", bus.perf_wb_threads, 1);

      // 6: thread counter wrap.
      do_reset();
      force dut.perf_threads_q = 44'hFFF_FFFF_FFFE;
      #1 release dut.perf_threads_q;
      b = mk(2'd0, 5'd1, 4'b1111, 32'h7777_0000, 1'b1);
      drive(WB_ALU, 1'b1, b);
      expq.push_back(b);
      step();
      clear_all();
      step();
      step();
      check("t6_threads_wrap", bus.perf_wb_threads, 2);
      check("t6_beats", bus.perf_wb_beats, 1);

      for (int i = 0; i < 10 && expq.size() != 0; i++) step();
      check("drain_queue", 64'(expq.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
